data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised byte-addressable data memory for the simplified RISC-V core's load/store unit. It accepts one request per cycle over a valid/ready handshake and supports byte, half-word, word and double-word accesses with sign or zero extension. Responses return in order after a configurable fixed latency. After every reset, a hardware sweep zeroes the whole array, so no read can return data that was not written since reset.

## Interface
Parameters:
- AWIDTH, 10, byte-address width; addresses cover 2**AWIDTH bytes.
- DWIDTH, 32, data width; legal values are 32 or 64.
- LATENCY, 1, cycles from request acceptance to response; legal range 1..4.
- MWIDTH (localparam), DWIDTH/8, byte lanes per word.
- DEPTH (localparam), 2**AWIDTH/MWIDTH, number of words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_we  in  1  1 = store, 0 = load
- req_addr  in  AWIDTH  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  DWIDTH  store data, right-aligned (lane 0)
- rsp_valid  out  1  response valid for one cycle
- rsp_rdata  out  DWIDTH  load data, right-aligned and extended
- rsp_err  out  1  request was rejected (misaligned or illegal size)
- init_done  out  1  zeroing sweep complete

## Operation
- FSM states:
  - INIT: entered on reset; a word counter writes 0 to index 0..DEPTH-1, one word per cycle; req_ready=0.
  - RUN: entered after the last word is written; req_ready=1 and init_done=1. The FSM stays in RUN until reset.
- A request is accepted when req_valid && req_ready. Every accepted request, load or store, produces exactly one response.
- Error when any of the following holds:
  - req_addr % (1<<req_size) != 0;
  - req_size==3 with DWIDTH==32.
- On error: no array update, rsp_err=1, rsp_rdata=0.
- Lane offset = req_addr[$clog2(MWIDTH)-1:0]. Word index = req_addr >> $clog2(MWIDTH).
- Store:
  - Byte enable = ((1<<(1<<req_size))-1) << offset.
  - Data = req_wdata << (8*offset).
  - Only enabled bytes change.
  - Response has rsp_rdata=0 and rsp_err=0.
- Load:
  - Read the word, shift right by 8*offset, and keep the low 8<<req_size bits.
  - Sign-extend from the top kept bit unless req_unsigned, or unless the access is full width.
- Outputs when rsp_valid=0: rsp_rdata=0 and rsp_err=0.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, FSM=INIT, counter=0. Array contents are not reset; the sweep clears them.
- init_done and req_ready rise exactly DEPTH rising edges after rst_n deasserts.
- A request accepted at edge n produces its response valid in the cycle following edge n+LATENCY.
- Throughput is one request per cycle; responses come out in acceptance order. There is no response backpressure.
- A store accepted at edge n is visible to a load accepted at edge n+1 or later. Read-after-write is always coherent.
- Reset mid-operation: all in-flight responses are dropped immediately (rsp_valid=0 asynchronously), the FSM returns to INIT, and the sweep reruns.
- req_valid asserted during INIT is ignored and not queued.

## Structure
- data_mem_pkg holds:
  - size_e (SZ_B, SZ_H, SZ_W, SZ_D);
  - byte-enable function be_gen(size, offset, MWIDTH);
  - extension function ext_load(word, size, offset, unsigned).
- Sub-module data_mem_array: a DEPTH x DWIDTH storage array with per-byte write enable and one synchronous read port.
- Top level contains the INIT/RUN FSM, the sweep counter, request decode, and a LATENCY-deep response pipeline of valid/err/data registers.

## Test plan
Configuration for all scenarios: AWIDTH=10, DWIDTH=32, LATENCY=2, DEPTH=256.
- Reset, hold req_valid=1 -> req_ready stays 0 for 256 cycles; first accepted load of word 0x10 returns 0x00000000 with rsp_err=0.
- Store word 0x80818283 at 0x20, then:
  - signed load byte at 0x21 -> 0xFFFFFF82;
  - unsigned load byte at 0x21 -> 0x00000082;
  - signed load half at 0x22 -> 0xFFFF8081.
- Store word 0x11223344 at 0x30, store byte 0x5A at 0x33, load word at 0x30 -> 0x5A223344.
- Misaligned and illegal sizes:
  - load half at 0x41 -> rsp_err=1, rsp_rdata=0;
  - store word at 0x42 -> rsp_err=1, word 0x40 unchanged;
  - req_size=3 -> rsp_err=1.
- Store 0x000000AA at 0x50 in cycle n and load 0x50 in cycle n+1 -> load response 0xAA appears LATENCY cycles after its acceptance. Then 8 back-to-back loads -> 8 consecutive rsp_valid cycles in order.
- Assert rst_n with 2 loads in flight -> rsp_valid drops immediately and no stale response appears after release. After 256 cycles, load of 0x50 returns 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the load/store data memory: access-size
// encoding, controller states, byte-enable generation and load extension.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Byte enables for an access of the given size starting at lane 'offset'.
    // Computed on an 8-lane vector; lanes at or above 'mwidth' are cleared.
    function automatic logic [7:0] be_gen(input size_e size,
                                          input logic [2:0] offset,
                                          input int mwidth);
        logic [15:0] mask;
        logic [15:0] lanes;
        mask  = (16'd1 << (4'd1 << size)) - 16'd1;
        mask  = mask << offset;
        lanes = (16'd1 << mwidth) - 16'd1;
        return 8'(mask & lanes);
    endfunction

    // Right-align the addressed bytes of a word and extend them to 64 bits.
    // A full-width double-word load needs no extension; for a full-width
    // word in a 32-bit memory the extended upper half is discarded.
    function automatic logic [63:0] ext_load(input logic [63:0] word,
                                             input size_e size,
                                             input logic [2:0] offset,
                                             input logic is_unsigned);
        logic [63:0] sh;
        sh = word >> {offset, 3'b000};
        case (size)
            SZ_B:    return is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SZ_H:    return is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    return is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DWIDTH storage with per-byte write enables and one synchronous
// read port. Contents are not reset; the controller sweeps them to zero.
module data_mem_array #(
    parameter int DEPTH  = 256,
    parameter int DWIDTH = 32,
    parameter int MWIDTH = DWIDTH / 8,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [MWIDTH-1:0] we,
    input  logic [IW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [IW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Byte-lane writes: only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        for (int b = 0; b < MWIDTH; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Registered read; a write and a read never target the same cycle.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory for the load/store unit. Zeroes the whole
// array after reset, then accepts one request per cycle and returns
// in-order responses after a fixed LATENCY.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int AWIDTH  = 10,
    parameter int DWIDTH  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int MWIDTH = DWIDTH / 8;
    localparam int DEPTH  = (2 ** AWIDTH) / MWIDTH;
    localparam int OW     = $clog2(MWIDTH);
    localparam int IW     = AWIDTH - OW;

    state_e            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;

    logic              accept;
    size_e             size_in;
    logic [2:0]        off_in;
    logic [IW-1:0]     idx_in;
    logic              misalign;
    logic              err_req;
    logic [7:0]        be_full;
    logic [DWIDTH-1:0] wdata_sh;

    logic [MWIDTH-1:0] arr_we;
    logic [IW-1:0]     arr_waddr;
    logic [DWIDTH-1:0] arr_wdata;
    logic              arr_re;

    logic              vld_p0;
    logic              err_p0;
    logic              we_p0;
    size_e             size_p0;
    logic [2:0]        off_p0;
    logic              uns_p0;
    logic [DWIDTH-1:0] rdata_p0;
    logic [63:0]       ld_full;
    logic [DWIDTH-1:0] fmt_p0;

    logic              vld_pn  [LATENCY];
    logic              err_pn  [LATENCY];
    logic [DWIDTH-1:0] data_pn [LATENCY];

    logic              unused_bits;

    // Request decode: alignment check, lane offset, word index, lane data.
    always_comb begin
        accept   = req_valid && (state_q == ST_RUN);
        size_in  = size_e'(req_size);
        off_in   = 3'(req_addr[OW-1:0]);
        idx_in   = req_addr[AWIDTH-1:OW];
        case (size_in)
            SZ_B:    misalign = 1'b0;
            SZ_H:    misalign = req_addr[0];
            SZ_W:    misalign = |req_addr[1:0];
            default: misalign = |req_addr[2:0];
        endcase
        err_req  = misalign || ((size_in == SZ_D) && (DWIDTH < 64));
        be_full  = be_gen(size_in, off_in, MWIDTH);
        wdata_sh = req_wdata << {off_in, 3'b000};
    end

    // State and sweep-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, handshake outputs and array write-port steering.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        init_done = 1'b0;
        arr_we    = '0;
        arr_waddr = idx_in;
        arr_wdata = wdata_sh;
        case (state_q)
            ST_INIT: begin
                arr_we    = '1;
                arr_waddr = cnt_q;
                arr_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == IW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                req_ready = 1'b1;
                init_done = 1'b1;
                if (accept && req_we && !err_req) begin
                    arr_we = be_full[MWIDTH-1:0];
                end
            end
        endcase
    end

    assign arr_re = accept && !req_we;

    data_mem_array #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH),
        .MWIDTH (MWIDTH),
        .IW     (IW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (idx_in),
        .rdata (rdata_p0)
    );

    // Stage p0: request accepted, array read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
        end
    end

    // Request attributes travelling with the read.
    always_ff @(posedge clk) begin
        if (accept) begin
            err_p0  <= err_req;
            we_p0   <= req_we;
            size_p0 <= size_in;
            off_p0  <= off_in;
            uns_p0  <= req_unsigned;
        end
    end

    // Load formatting; stores and rejected requests return zero data.
    always_comb begin
        ld_full = ext_load(64'(rdata_p0), size_p0, off_p0, uns_p0);
        fmt_p0  = (vld_p0 && !err_p0 && !we_p0) ? ld_full[DWIDTH-1:0] : '0;
    end

    // Stages p1..pLATENCY: response valid pipeline, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                vld_pn[k] <= 1'b0;
            end
        end else begin
            vld_pn[0] <= vld_p0;
            for (int k = 1; k < LATENCY; k++) begin
                vld_pn[k] <= vld_pn[k-1];
            end
        end
    end

    // Stages p1..pLATENCY: response error/data pipeline.
    always_ff @(posedge clk) begin
        err_pn[0]  <= vld_p0 && err_p0;
        data_pn[0] <= fmt_p0;
        for (int k = 1; k < LATENCY; k++) begin
            err_pn[k]  <= err_pn[k-1];
            data_pn[k] <= data_pn[k-1];
        end
    end

    assign rsp_valid = vld_pn[LATENCY-1];
    assign rsp_err   = vld_pn[LATENCY-1] && err_pn[LATENCY-1];
    assign rsp_rdata = vld_pn[LATENCY-1] ? data_pn[LATENCY-1] : '0;

    // Helper outputs are 8 lanes / 64 bits wide; narrow configs drop the top.
    assign unused_bits = ^{be_full, ld_full};

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (AWIDTH=10, DWIDTH=32, LATENCY=2).
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(
        .AWIDTH  (10),
        .DWIDTH  (32),
        .LATENCY (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [9:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
    endtask

    // One isolated transaction: accept, then check exact LATENCY=2 timing.
    task automatic txn(input string tag, input logic we, input logic [9:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err);
        drive(we, addr, size, uns, wdata);
        step();
        req_valid = 1'b0;
        step();
        chk({tag, "_early"}, 32'(rsp_valid), 32'd0);
        step();
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, rsp_rdata, exp_data);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    // Sweep must hold ready low for 255 edges and raise it on the 256th.
    task automatic wait_init(input string tag);
        logic bad;
        bad = 1'b0;
        for (int i = 1; i < 256; i++) begin
            step();
            if (req_ready !== 1'b0 || init_done !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
        end
        chk({tag, "_hold"}, 32'(bad), 32'd0);
        step();
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_done"}, 32'(init_done), 32'd1);
        chk({tag, "_norsp"}, 32'(rsp_valid), 32'd0);
    endtask

    logic [9:0]  b2b_addr [8];
    logic [31:0] b2b_exp  [8];

    initial begin
        b2b_addr = '{10'h020, 10'h021, 10'h022, 10'h023, 10'h030, 10'h031, 10'h032, 10'h033};
        b2b_exp  = '{32'h83, 32'h82, 32'h81, 32'h80, 32'h44, 32'h33, 32'h22, 32'h5A};

        rst_n        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);

        // Request held during the sweep is ignored; accepted once ready.
        drive(1'b0, 10'h010, 2'd2, 1'b0, 32'd0);
        rst_n = 1'b1;
        wait_init("init1");
        step();
        req_valid = 1'b0;
        step();
        chk("first_early", 32'(rsp_valid), 32'd0);
        step();
        chk("first_vld", 32'(rsp_valid), 32'd1);
        chk("first_data", rsp_rdata, 32'd0);
        chk("first_err", 32'(rsp_err), 32'd0);
        step();
        chk("first_single", 32'(rsp_valid), 32'd0);

        // Sub-word loads with sign and zero extension.
        txn("st20",   1'b1, 10'h020, 2'd2, 1'b0, 32'h80818283, 32'h0, 1'b0);
        txn("lb21s",  1'b0, 10'h021, 2'd0, 1'b0, 32'h0, 32'hFFFFFF82, 1'b0);
        txn("lb21u",  1'b0, 10'h021, 2'd0, 1'b1, 32'h0, 32'h00000082, 1'b0);
        txn("lh22s",  1'b0, 10'h022, 2'd1, 1'b0, 32'h0, 32'hFFFF8081, 1'b0);

        // Byte store merges into an existing word.
        txn("st30",   1'b1, 10'h030, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0);
        txn("sb33",   1'b1, 10'h033, 2'd0, 1'b0, 32'h0000005A, 32'h0, 1'b0);
        txn("lw30",   1'b0, 10'h030, 2'd2, 1'b0, 32'h0, 32'h5A223344, 1'b0);

        // Misaligned and illegal-size requests.
        txn("lh41",   1'b0, 10'h041, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
        txn("st40",   1'b1, 10'h040, 2'd2, 1'b0, 32'hCAFEBABE, 32'h0, 1'b0);
        txn("sw42",   1'b1, 10'h042, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b1);
        txn("lw40",   1'b0, 10'h040, 2'd2, 1'b0, 32'h0, 32'hCAFEBABE, 1'b0);
        txn("ld48",   1'b0, 10'h048, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
        txn("sd48",   1'b1, 10'h048, 2'd3, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("lw48",   1'b0, 10'h048, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);

        // Store followed immediately by a load of the same word.
        drive(1'b1, 10'h050, 2'd2, 1'b0, 32'h000000AA);
        step();
        drive(1'b0, 10'h050, 2'd2, 1'b0, 32'h0);
        step();
        req_valid = 1'b0;
        chk("raw_early", 32'(rsp_valid), 32'd0);
        step();
        chk("raw_st_vld", 32'(rsp_valid), 32'd1);
        chk("raw_st_data", rsp_rdata, 32'd0);
        step();
        chk("raw_ld_vld", 32'(rsp_valid), 32'd1);
        chk("raw_ld_data", rsp_rdata, 32'h000000AA);

        // Eight back-to-back unsigned byte loads, responses in order.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b0, b2b_addr[i], 2'd0, 1'b1, 32'h0);
            else req_valid = 1'b0;
            step();
            if (i >= 2) begin
                chk($sformatf("b2b%0d_vld", i - 2), 32'(rsp_valid), 32'd1);
                chk($sformatf("b2b%0d_data", i - 2), rsp_rdata, b2b_exp[i-2]);
            end
        end
        step();
        chk("b2b_end", 32'(rsp_valid), 32'd0);

        // Reset with two loads in flight.
        drive(1'b0, 10'h050, 2'd2, 1'b0, 32'h0);
        step();
        step();
        req_valid = 1'b0;
        step();
        chk("mid_vld_before", 32'(rsp_valid), 32'd1);
        chk("mid_data_before", rsp_rdata, 32'h000000AA);
        rst_n = 1'b0;
        #1;
        chk("mid_vld_drop", 32'(rsp_valid), 32'd0);
        chk("mid_rdata_drop", rsp_rdata, 32'd0);
        chk("mid_ready_drop", 32'(req_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        wait_init("init2");
        txn("post_lw50", 1'b0, 10'h050, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
